axi_lite_master: RTL and testbench

//  AXI4-lite initiator for the peripheral register slaves (UART regs and similar).

---
 rtl/axi_lite_master.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-lite initiator: one CPU-side request becomes one AXI4-lite write or read, response returned on rsp_*.
// Latency (zero-wait slave): request accepted in cycle T, AW/W or AR handshake T+1, B/R at T+2, rsp_valid at T+3.
// Backpressure: req_ready only in IDLE (one transaction in flight); every AXI VALID holds until its READY arrives.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // CPU-side request / response
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  // write address channel
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [2:0]                AWPROT,
  // write data channel
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  // write response channel
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP,
  // read address channel
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [2:0]                ARPROT,
  // read data channel
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  // Each VALID register doubles as the "handshake still pending" flag for its channel.
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

  logic                    w_req_hs;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_b_hs;
  logic                    w_r_hs;

  assign w_req_hs  = req_valid && (r_state == S_IDLE);
  // A channel counts as done if it already handshook or is handshaking this cycle.
  assign w_aw_done = !r_awvalid || AWREADY;
  assign w_w_done  = !r_wvalid  || WREADY;
  assign w_b_hs    = (r_state == S_WR_RESP) && BVALID;
  assign w_r_hs    = (r_state == S_RD_DATA) && RVALID;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = req_write ? S_WR_REQ : S_RD_ADDR;
      end
      S_WR_REQ: begin
        if (w_aw_done && w_w_done) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) w_next = S_RESP;
      end
      S_RD_ADDR: begin
        if (ARREADY) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        RREADY = 1'b1;
        if (RVALID) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request payload on acceptance; held afterwards as the channel address/data.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_req_hs) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Channel VALIDs: raised on acceptance, each dropped after its own handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
    end else if (w_req_hs) begin
      r_awvalid <= req_write;
      r_wvalid  <= req_write;
      r_arvalid <= !req_write;
    end else begin
      if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
      if (r_wvalid  && WREADY)  r_wvalid  <= 1'b0;
      if (r_arvalid && ARREADY) r_arvalid <= 1'b0;
    end
  end

  // Response payload, held until the next B or R is taken.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_b_hs) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= |BRESP;
    end else if (w_r_hs) begin
      r_rsp_rdata <= RDATA;
      r_rsp_err   <= |RRESP;
    end
  end

  assign AWVALID   = r_awvalid;
  assign AWADDR    = r_addr;
  assign AWPROT    = 3'b000;
  assign WVALID    = r_wvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wvalid ? r_wstrb : '0;
  assign ARVALID   = r_arvalid;
  assign ARADDR    = r_addr;
  assign ARPROT    = 3'b000;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed cases plus random transactions against a scoreboard.
// A slave model answers each channel with programmable delays; a monitor checks every response.
// Expected response and latency are derived from the transaction description alone.
module tb_axi_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        AWVALID, AWREADY = 1'b0;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID = 1'b0, BREADY;
  logic [1:0]  BRESP = 2'b00;
  logic        ARVALID, ARREADY = 1'b0;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID = 1'b0, RREADY;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = 2'b00;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t_req;
  } exp_t;

  txn_t slave_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rdata, input logic [1:0] resp,
                              input int awd, input int wd, input int bd, input int ard, input int rd);
    txn_t t;
    t.write = wr; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.rdata = rdata; t.resp = resp;
    t.aw_dly = awd; t.w_dly = wd; t.b_dly = bd; t.ar_dly = ard; t.r_dly = rd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(0, 15)),
              $urandom(), 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  // ---------------- slave model ----------------
  task automatic slv_aw(input txn_t t);
    int n = 0;
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (AWVALID) begin
        chk("aw_addr", AWADDR, t.addr);
        chk("aw_prot", 32'(AWPROT), 0);
        if (n == t.aw_dly) begin
          AWREADY = 1'b1;
          @(negedge ACLK);
          AWREADY = 1'b0;
          chk("aw_drop", 32'(AWVALID), 0);
          ok = 1;
          break;
        end
        n++;
      end
      @(negedge ACLK);
    end
    if (!ok) timeout("aw_wait");
  endtask

  task automatic slv_w(input txn_t t);
    int n = 0;
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (WVALID) begin
        chk("w_data", WDATA, t.wdata);
        chk("w_strb", 32'(WSTRB), 32'(t.wstrb));
        if (n == t.w_dly) begin
          WREADY = 1'b1;
          @(negedge ACLK);
          WREADY = 1'b0;
          chk("w_drop", 32'(WVALID), 0);
          chk("w_strb_idle", 32'(WSTRB), 0);
          ok = 1;
          break;
        end
        n++;
      end
      @(negedge ACLK);
    end
    if (!ok) timeout("w_wait");
  endtask

  task automatic slv_ar(input txn_t t);
    int n = 0;
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (ARVALID) begin
        chk("ar_addr", ARADDR, t.addr);
        chk("ar_prot", 32'(ARPROT), 0);
        if (n == t.ar_dly) begin
          ARREADY = 1'b1;
          @(negedge ACLK);
          ARREADY = 1'b0;
          chk("ar_drop", 32'(ARVALID), 0);
          ok = 1;
          break;
        end
        n++;
      end
      @(negedge ACLK);
    end
    if (!ok) timeout("ar_wait");
  endtask

  task automatic slv_b(input txn_t t);
    bit ok = 0;
    repeat (t.b_dly) @(negedge ACLK);
    BRESP  = t.resp;
    BVALID = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (BREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    if (ok) begin
      @(negedge ACLK);
      BVALID = 1'b0;
      BRESP  = 2'b00;
      chk("b_single", 32'(BREADY), 0);
    end else begin
      BVALID = 1'b0;
      timeout("b_wait");
    end
  endtask

  task automatic slv_r(input txn_t t);
    bit ok = 0;
    repeat (t.r_dly) @(negedge ACLK);
    RDATA  = t.rdata;
    RRESP  = t.resp;
    RVALID = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (RREADY) begin ok = 1; break; end
      @(negedge ACLK);
    end
    if (ok) begin
      @(negedge ACLK);
      RVALID = 1'b0;
      RRESP  = 2'b00;
      RDATA  = $urandom();
      chk("r_single", 32'(RREADY), 0);
    end else begin
      RVALID = 1'b0;
      timeout("r_wait");
    end
  endtask

  initial begin
    txn_t t;
    forever begin
      wait (slave_q.size() != 0);
      t = slave_q.pop_front();
      @(negedge ACLK);
      if (t.write) begin
        fork
          slv_aw(t);
          slv_w(t);
        join
        slv_b(t);
      end else begin
        slv_ar(t);
        slv_r(t);
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  logic        prev_rv = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(negedge ACLK) begin
    exp_t e;
    if (!ARESETn) begin
      have_last = 1'b0;
      prev_rv   = 1'b0;
    end else begin
      if (rsp_valid) begin
        chk("rsp_single_pulse", 32'(prev_rv), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid with no pending request (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.t_req), 32'(e.lat));
          done_cnt++;
          last_rdata = e.rdata;
          last_err   = e.err;
          have_last  = 1'b1;
        end
      end else if (have_last) begin
        chk("rsp_rdata_hold", rsp_rdata, last_rdata);
        chk("rsp_err_hold", 32'(rsp_err), 32'(last_err));
      end
      prev_rv = rsp_valid;
    end
  end

  // ---------------- request driver ----------------
  task automatic run_txn(input txn_t t, input bit poke);
    exp_t e;
    bit   acc = 0;
    int   target;
    @(negedge ACLK);
    req_valid = 1'b1;
    req_write = t.write;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_wstrb = t.wstrb;
    for (int k = 0; k < 100; k++) begin
      if (req_ready) begin acc = 1; break; end
      @(negedge ACLK);
    end
    if (!acc) begin
      req_valid = 1'b0;
      timeout("req_accept");
      return;
    end
    e.rdata = t.write ? 32'h0 : t.rdata;
    e.err   = |t.resp;
    e.lat   = t.write ? 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly
                      : 3 + t.ar_dly + t.r_dly;
    e.t_req = cyc;
    target  = done_cnt + 1;
    exp_q.push_back(e);
    slave_q.push_back(t);
    @(negedge ACLK);
    if (poke) begin
      req_write = 1'b0;
      req_addr  = $urandom() & 32'hFFFF_FFFC;
      for (int k = 0; k < 2; k++) begin
        chk("busy_req_ready", 32'(req_ready), 0);
        @(negedge ACLK);
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done_cnt >= target) break;
      @(negedge ACLK);
    end
    if (done_cnt < target) timeout("rsp_wait");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_awvalid", 32'(AWVALID), 0);
    chk("rst_wvalid", 32'(WVALID), 0);
    chk("rst_arvalid", 32'(ARVALID), 0);
    chk("rst_bready", 32'(BREADY), 0);
    chk("rst_rready", 32'(RREADY), 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_wstrb", 32'(WSTRB), 0);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;

    // zero-wait write
    run_txn(mk(1'b1, 32'h0000_0008, 32'h0000_0055, 4'b0001, 32'h0, 2'b00, 0, 0, 0, 0, 0), 1'b0);
    // same write, W accepted three cycles after AW
    run_txn(mk(1'b1, 32'h0000_0008, 32'h0000_0055, 4'b0001, 32'h0, 2'b00, 0, 3, 0, 0, 0), 1'b0);
    // W before AW, slow B with SLVERR
    run_txn(mk(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 32'h0, 2'b10, 2, 0, 2, 0, 0), 1'b0);
    // read with 4-cycle RVALID delay
    run_txn(mk(1'b0, 32'h0000_0010, 32'h0, 4'b0, 32'h0000_0003, 2'b00, 0, 0, 0, 0, 4), 1'b0);
    // read returning SLVERR while a second request is presented
    run_txn(mk(1'b0, 32'h0000_0014, 32'h0, 4'b0, 32'hA5A5_0001, 2'b10, 0, 0, 0, 0, 2), 1'b1);
    // read with slow ARREADY
    run_txn(mk(1'b0, 32'h0000_0018, 32'h0, 4'b0, 32'h1234_5678, 2'b11, 3, 0, 0, 3, 1), 1'b0);

    // reset in the middle of a write address phase
    @(negedge ACLK);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h0000_00AA;
    req_wstrb = 4'b0011;
    chk("rst_test_req_ready", 32'(req_ready), 1);
    @(negedge ACLK);
    req_valid = 1'b0;
    chk("rst_test_awvalid_before", 32'(AWVALID), 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("rst_mid_awvalid", 32'(AWVALID), 0);
    chk("rst_mid_wvalid", 32'(WVALID), 0);
    chk("rst_mid_arvalid", 32'(ARVALID), 0);
    chk("rst_mid_bready", 32'(BREADY), 0);
    chk("rst_mid_rready", 32'(RREADY), 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_release_req_ready", 32'(req_ready), 1);
    run_txn(mk(1'b0, 32'h0000_0010, 32'h0, 4'b0, 32'h0000_0077, 2'b00, 0, 0, 0, 0, 0), 1'b0);

    for (int i = 0; i < 30; i++) run_txn(rand_txn(), 1'($urandom_range(0, 1)));

    repeat (5) @(negedge ACLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
